// File: rtl/lif_step_scheduler_pkg.sv
// Shared types and helpers for the time-multiplexed LIF step scheduler.
package lif_step_scheduler_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Unsigned add clamped at the all-ones value instead of wrapping.
    function automatic data_t sat_add(input data_t a, input data_t b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/lif_step_scheduler_if.sv
// Control/data bundle between the scheduler and its host: current events,
// threshold writes, step control and the spike output stream.
interface lif_step_scheduler_if #(
    parameter int N_NEUR = 8
);
    import lif_step_scheduler_pkg::*;

    localparam int IDX_W = $clog2(N_NEUR);
    localparam int CNT_W = IDX_W + 1;

    logic             cur_valid;
    logic             cur_ready;
    logic [IDX_W-1:0] cur_idx;
    data_t            cur_data;
    logic             thr_we;
    data_t            thr_data;
    logic             step_start;
    logic             spk_valid;
    logic             spk_ready;
    logic [IDX_W-1:0] spk_idx;
    logic             busy;
    logic             step_done;
    logic [CNT_W-1:0] active_cnt;

    modport master (
        output cur_valid, cur_idx, cur_data, thr_we, thr_data, step_start, spk_ready,
        input  cur_ready, spk_valid, spk_idx, busy, step_done, active_cnt
    );

    modport slave (
        input  cur_valid, cur_idx, cur_data, thr_we, thr_data, step_start, spk_ready,
        output cur_ready, spk_valid, spk_idx, busy, step_done, active_cnt
    );

endinterface

// File: rtl/lif_step_scheduler_update.sv
// Combinational leaky integrate-and-fire update for one neuron; the scheduler
// shares a single instance across all virtual neurons.
module lif_update
    import lif_step_scheduler_pkg::*;
(
    input  data_t i_u,
    input  data_t i_cur,
    input  data_t i_thr,
    output data_t o_u_next,
    output logic  o_spike
);

    // A firing neuron restarts from this step's input; otherwise the membrane
    // leaks by half and integrates the buffered current.
    assign o_spike  = (i_u >= i_thr);
    assign o_u_next = o_spike ? i_cur : sat_add(i_cur, i_u >> 1);

endmodule

// File: rtl/lif_step_scheduler.sv
// Timestep scheduler: walks N_NEUR virtual neurons through one shared LIF
// datapath, skipping quiescent ones and streaming spike indices downstream.
module lif_step_scheduler
    import lif_step_scheduler_pkg::*;
#(
    parameter int N_NEUR = 8,
    parameter int TH_RST = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lif_step_scheduler_if.slave   bus_if
);

    localparam int               IDX_W    = $clog2(N_NEUR);
    localparam int               CNT_W    = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEUR - 1);

    state_t           r_state;
    state_t           w_state_next;
    data_t            r_cur_buf [N_NEUR];
    data_t            r_u       [N_NEUR];
    data_t            r_thr;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_spk_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active_cnt;

    data_t w_cur_sel;
    data_t w_u_sel;
    data_t w_u_next;
    logic  w_spike;
    logic  w_skip;
    logic  w_fire;
    logic  w_last;
    logic  w_cur_acc;
    logic  w_cur_ready;
    logic  w_busy;
    logic  w_spk_valid;
    logic  w_step_done;

    assign w_cur_sel = r_cur_buf[r_idx];
    assign w_u_sel   = r_u[r_idx];
    assign w_skip    = (w_cur_sel == '0) && (w_u_sel == '0);
    assign w_fire    = !w_skip && w_spike;
    assign w_last    = (r_idx == LAST_IDX);
    assign w_cur_acc = bus_if.cur_valid && w_cur_ready;

    lif_update u_lif_update (
        .i_u      (w_u_sel),
        .i_cur    (w_cur_sel),
        .i_thr    (r_thr),
        .o_u_next (w_u_next),
        .o_spike  (w_spike)
    );

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_cur_ready  = 1'b0;
        w_busy       = 1'b1;
        w_spk_valid  = 1'b0;
        w_step_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cur_ready = 1'b1;
                w_busy      = 1'b0;
                if (bus_if.step_start) w_state_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (w_fire)      w_state_next = ST_EMIT;
                else if (w_last) w_state_next = ST_DONE;
            end
            ST_EMIT: begin
                w_spk_valid = 1'b1;
                if (bus_if.spk_ready) w_state_next = w_last ? ST_DONE : ST_SCAN;
            end
            ST_DONE: begin
                w_step_done  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_thr        <= data_t'(TH_RST);
            r_idx        <= '0;
            r_spk_idx    <= '0;
            r_cnt        <= '0;
            r_active_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (bus_if.thr_we) r_thr <= bus_if.thr_data;
                    if (bus_if.step_start) begin
                        r_idx <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_SCAN: begin
                    if (!w_skip) r_cnt <= r_cnt + CNT_W'(1);
                    if (w_fire)       r_spk_idx <= r_idx;
                    else if (!w_last) r_idx     <= r_idx + IDX_W'(1);
                end
                ST_EMIT: begin
                    if (bus_if.spk_ready && !w_last) r_idx <= r_idx + IDX_W'(1);
                end
                ST_DONE: r_active_cnt <= r_cnt;
                default: ;
            endcase
        end
    end

    // NOTE: neuron state lives in flops rather than a RAM because every entry
    // must come out of reset cleared; a RAM macro could not be reset this way.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEUR; i++) begin
                r_cur_buf[i] <= '0;
                r_u[i]       <= '0;
            end
        end else if (w_cur_acc) begin
            r_cur_buf[bus_if.cur_idx] <= sat_add(r_cur_buf[bus_if.cur_idx], bus_if.cur_data);
        end else if (r_state == ST_SCAN && !w_skip) begin
            r_u[r_idx]       <= w_u_next;
            r_cur_buf[r_idx] <= '0;
        end
    end

    assign bus_if.cur_ready  = w_cur_ready;
    assign bus_if.busy       = w_busy;
    assign bus_if.spk_valid  = w_spk_valid;
    assign bus_if.step_done  = w_step_done;
    assign bus_if.spk_idx    = r_spk_idx;
    assign bus_if.active_cnt = r_active_cnt;

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Scoreboard bench for lif_step_scheduler: directed steps push expected spikes
// and step completions; a monitor pops and compares them as the DUT emits.
module tb_lif_step_scheduler;
    import lif_step_scheduler_pkg::*;

    localparam int N      = 8;
    localparam int TH     = 32;
    localparam int LAT0   = N + 1;

    typedef struct {
        bit is_done;
        int val;
        int lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   t_start;
    int   n_checks;
    int   n_errors;
    int   cnt_exp;
    bit   cnt_pending;
    exp_t sb_q[$];

    lif_step_scheduler_if #(.N_NEUR(N)) bus_if ();

    lif_step_scheduler #(.N_NEUR(N), .TH_RST(TH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_unexpected(input string name, input int val);
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_%s: got %0d with no matching expectation (cycle %0d)", name, val, cyc);
    endtask

    function automatic void push_spike(input int idx);
        sb_q.push_back('{1'b0, idx, 0});
    endfunction

    task automatic write_cur(input int idx, input int data);
        bus_if.cur_valid = 1'b1;
        bus_if.cur_idx   = 3'(idx);
        bus_if.cur_data  = 8'(data);
        @(negedge clk);
        bus_if.cur_valid = 1'b0;
    endtask

    // Starts a step (optionally with a same-cycle threshold write and current
    // write) and waits, bounded, for the scheduler to return to idle.
    task automatic run_step(input bit thr_en, input int thr_val, input bit cw_en,
                            input int cw_idx, input int cw_data,
                            input int exp_cnt, input int exp_lat);
        sb_q.push_back('{1'b1, exp_cnt, exp_lat});
        bus_if.step_start = 1'b1;
        bus_if.thr_we     = thr_en;
        bus_if.thr_data   = 8'(thr_val);
        bus_if.cur_valid  = cw_en;
        bus_if.cur_idx    = 3'(cw_idx);
        bus_if.cur_data   = 8'(cw_data);
        t_start = cyc;
        @(negedge clk);
        bus_if.step_start = 1'b0;
        bus_if.thr_we     = 1'b0;
        bus_if.cur_valid  = 1'b0;
        for (int k = 0; k < 400 && bus_if.busy; k++) @(negedge clk);
        if (bus_if.busy) check("step_timeout_busy", 1, 0);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (cnt_pending) begin
                check("active_cnt", int'(bus_if.active_cnt), cnt_exp);
                cnt_pending = 1'b0;
            end
            if (rst_n) begin
                if (bus_if.spk_valid) begin
                    if (sb_q.size() == 0 || sb_q[0].is_done) begin
                        if (bus_if.spk_ready) report_unexpected("spike", int'(bus_if.spk_idx));
                    end else if (bus_if.spk_ready) begin
                        e = sb_q.pop_front();
                        check("spk_idx", int'(bus_if.spk_idx), e.val);
                    end else begin
                        check("spk_idx_hold", int'(bus_if.spk_idx), sb_q[0].val);
                    end
                end
                if (bus_if.step_done) begin
                    if (sb_q.size() == 0 || !sb_q[0].is_done) begin
                        report_unexpected("step_done", cyc - t_start);
                    end else begin
                        e = sb_q.pop_front();
                        check("step_latency", cyc - t_start, e.lat);
                        cnt_exp     = e.val;
                        cnt_pending = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        n_checks    = 0;
        n_errors    = 0;
        cnt_pending = 1'b0;
        t_start     = 0;
        rst_n             = 1'b0;
        bus_if.cur_valid  = 1'b0;
        bus_if.cur_idx    = '0;
        bus_if.cur_data   = '0;
        bus_if.thr_we     = 1'b0;
        bus_if.thr_data   = '0;
        bus_if.step_start = 1'b0;
        bus_if.spk_ready  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cur_ready",  int'(bus_if.cur_ready),  1);
        check("rst_busy",       int'(bus_if.busy),       0);
        check("rst_spk_valid",  int'(bus_if.spk_valid),  0);
        check("rst_step_done",  int'(bus_if.step_done),  0);
        check("rst_active_cnt", int'(bus_if.active_cnt), 0);
        check("rst_spk_idx",    int'(bus_if.spk_idx),    0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty network: every neuron skipped.
        run_step(0, 0, 0, 0, 0, 0, LAT0);

        // idx3 integrates 40, then fires on the following step and resets.
        write_cur(3, 40);
        run_step(0, 0, 0, 0, 0, 1, LAT0);
        push_spike(3);
        run_step(0, 0, 0, 0, 0, 1, LAT0 + 1);
        run_step(0, 0, 0, 0, 0, 0, LAT0);

        // Saturating accumulate 200+100 -> 255; threshold 255 proves u[1]=255.
        write_cur(1, 200);
        write_cur(1, 100);
        run_step(0, 0, 0, 0, 0, 1, LAT0);
        push_spike(1);
        run_step(1, 255, 0, 0, 0, 1, LAT0 + 1);
        bus_if.thr_we   = 1'b1;
        bus_if.thr_data = 8'(TH);
        @(negedge clk);
        bus_if.thr_we   = 1'b0;

        // Two spikes; the first is stalled 4 cycles by spk_ready low.
        write_cur(0, 40);
        write_cur(5, 50);
        run_step(0, 0, 0, 0, 0, 2, LAT0);
        push_spike(0);
        push_spike(5);
        bus_if.spk_ready = 1'b0;
        fork
            run_step(0, 0, 0, 0, 0, 2, LAT0 + 6);
            begin
                int seen;
                seen = 0;
                for (int k = 0; k < 200 && seen < 4; k++) begin
                    @(negedge clk);
                    #1;
                    if (bus_if.spk_valid) seen++;
                end
                @(negedge clk);
                bus_if.spk_ready = 1'b1;
            end
        join
        run_step(0, 0, 0, 0, 0, 0, LAT0);

        // Threshold 10 written with step_start; busy-time requests ignored.
        write_cur(2, 12);
        run_step(0, 0, 0, 0, 0, 1, LAT0);
        push_spike(2);
        fork
            run_step(1, 10, 0, 0, 0, 1, LAT0 + 1);
            begin
                repeat (3) @(negedge clk);
                bus_if.cur_valid  = 1'b1;
                bus_if.cur_idx    = 3'd4;
                bus_if.cur_data   = 8'd77;
                bus_if.thr_we     = 1'b1;
                bus_if.thr_data   = 8'd200;
                bus_if.step_start = 1'b1;
                #1;
                check("busy_cur_ready", int'(bus_if.cur_ready), 0);
                check("busy_flag",      int'(bus_if.busy),      1);
                @(negedge clk);
                bus_if.cur_valid  = 1'b0;
                bus_if.thr_we     = 1'b0;
                bus_if.step_start = 1'b0;
            end
        join
        // Same-cycle write + start: idx7 seen by this step, idx4 untouched.
        run_step(0, 0, 1, 7, 5, 1, LAT0);
        // u7=5 leaks to 2; idx6 integrates 12.
        write_cur(6, 12);
        run_step(0, 0, 0, 0, 0, 2, LAT0);

        // Reset while holding a spike in EMIT (fires only if threshold is 10).
        bus_if.spk_ready  = 1'b0;
        bus_if.step_start = 1'b1;
        t_start = cyc;
        @(negedge clk);
        bus_if.step_start = 1'b0;
        for (int k = 0; k < 50 && !bus_if.spk_valid; k++) @(negedge clk);
        check("emit_before_reset", int'(bus_if.spk_valid), 1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("rst_mid_spk_valid", int'(bus_if.spk_valid), 0);
        check("rst_mid_busy",      int'(bus_if.busy),      0);
        check("rst_mid_step_done", int'(bus_if.step_done), 0);
        check("rst_mid_spk_idx",   int'(bus_if.spk_idx),   0);
        @(negedge clk);
        rst_n            = 1'b1;
        bus_if.spk_ready = 1'b1;
        repeat (N + 4) @(negedge clk);

        // Threshold back at 32 and membranes cleared: u2=20 must not fire.
        write_cur(2, 20);
        run_step(0, 0, 0, 0, 0, 1, LAT0);
        run_step(0, 0, 0, 0, 0, 1, LAT0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
